alu_issue_ctrl: RTL and testbench

//  Command sequencer directly upstream of the 8-bit ALU. Accepts one op per

---
 rtl/alu_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 8-bit ALU.
// Accepts one command per handshake and reads its operands from a 4x8
// register file (r0 reads as zero). It holds the ALU inputs for the whole
// pipeline latency, then writes the result back and latches the carry.
// Only one command is in flight at a time.
//
// state  | meaning
// IDLE   | ready for a command; ALU inputs hold the last issued op
// ISSUE  | operands on the ALU inputs; ALU samples them at the end of this cycle
// EXEC   | waiting out the rest of the ALU pipeline (wait_cnt down to zero)
// WB     | ALU result/carry valid; written back at the end of this cycle
module alu_issue_ctrl #(
  parameter int ALU_LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [2:0] i_cmd_op,
  input  logic [1:0] i_cmd_rd,
  input  logic [1:0] i_cmd_rs1,
  input  logic [1:0] i_cmd_rs2,
  input  logic       i_cmd_imm_en,
  input  logic [7:0] i_cmd_imm,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic [2:0] o_alu_op,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_carry,
  output logic       o_done,
  output logic [7:0] o_wb_data,
  output logic       o_carry_flag,
  output logic       o_busy,
  input  logic [1:0] i_dbg_addr,
  output logic [7:0] o_dbg_data
);

  // Wide enough to hold ALU_LAT-2, the reload value of the EXEC down-counter.
  localparam int CW = (ALU_LAT > 3) ? $clog2(ALU_LAT - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   wait_cnt_q;
  logic [1:0]      rd_q;
  logic [7:0]      rf [4];
  logic            done_q;
  logic            accept;

  assign accept       = i_cmd_valid && (state_q == S_IDLE);
  assign o_cmd_ready  = (state_q == S_IDLE);
  assign o_busy       = (state_q != S_IDLE);
  assign o_done       = done_q;

  // r0 is never written, so the explicit zero select only guards the read.
  assign o_dbg_data = (i_dbg_addr == 2'd0) ? 8'h00 : rf[i_dbg_addr];

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; EXEC leaves when the down-counter reaches terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_EXEC;
      S_EXEC:  if (wait_cnt_q == '0) state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // EXEC wait timer: loaded in ISSUE so EXEC lasts ALU_LAT-1 cycles.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      wait_cnt_q <= CW'(ALU_LAT - 2);
    end else if ((state_q == S_EXEC) && (wait_cnt_q != '0)) begin
      wait_cnt_q <= wait_cnt_q - 1'b1;
    end
  end

  // o_done is a registered decode of "entering WB", so it is high for all of WB.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_d == S_WB);
    end
  end

  // Operand capture at accept; the ALU inputs stay frozen until the next accept
  // because the ALU decodes its mode from the unregistered op select.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_alu_a  <= 8'h00;
      o_alu_b  <= 8'h00;
      o_alu_op <= 3'd0;
      rd_q     <= 2'd0;
    end else if (accept) begin
      o_alu_a  <= (i_cmd_rs1 == 2'd0) ? 8'h00 : rf[i_cmd_rs1];
      o_alu_b  <= i_cmd_imm_en ? i_cmd_imm :
                  ((i_cmd_rs2 == 2'd0) ? 8'h00 : rf[i_cmd_rs2]);
      o_alu_op <= i_cmd_op;
      rd_q     <= i_cmd_rd;
    end
  end

  // Write-back at the end of WB; a destination of r0 discards the result.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      o_wb_data    <= 8'h00;
      o_carry_flag <= 1'b0;
    end else if (state_q == S_WB) begin
      if (rd_q != 2'd0) rf[rd_q] <= i_alu_result;
      o_wb_data    <= i_alu_result;
      o_carry_flag <= i_alu_carry;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU feeds the DUT, and a cycle-count
// model of the sequencer is compared against the DUT on every falling edge.
module tb_alu_issue_ctrl;

  localparam int LAT = 3;   // accept edge to end of write-back

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic       o_cmd_ready;
  logic [2:0] i_cmd_op = 3'd0;
  logic [1:0] i_cmd_rd = 2'd0;
  logic [1:0] i_cmd_rs1 = 2'd0;
  logic [1:0] i_cmd_rs2 = 2'd0;
  logic       i_cmd_imm_en = 1'b0;
  logic [7:0] i_cmd_imm = 8'h00;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [2:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       i_alu_carry;
  logic       o_done;
  logic [7:0] o_wb_data;
  logic       o_carry_flag;
  logic       o_busy;
  logic [1:0] i_dbg_addr = 2'd0;
  logic [7:0] o_dbg_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  alu_issue_ctrl #(.ALU_LAT(2)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_rd(i_cmd_rd), .i_cmd_rs1(i_cmd_rs1),
    .i_cmd_rs2(i_cmd_rs2), .i_cmd_imm_en(i_cmd_imm_en), .i_cmd_imm(i_cmd_imm),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .i_alu_carry(i_alu_carry),
    .o_done(o_done), .o_wb_data(o_wb_data), .o_carry_flag(o_carry_flag),
    .o_busy(o_busy), .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  // ALU semantics: {carry, result}. SUB carry means "no borrow".
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a >= b), 8'(a - b)};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a[7], 8'(a << 1)};
      3'd6:    return {a[0], a >> 1};
      default: return {1'b0, a};
    endcase
  endfunction

  // Two-stage ALU: operands sampled at one edge, result registered at the next,
  // using the live op select at that second edge.
  logic [7:0] alu_ar = 8'h00;
  logic [7:0] alu_br = 8'h00;
  logic [8:0] alu_out = 9'h000;
  always @(posedge i_clk) begin
    alu_ar  <= o_alu_a;
    alu_br  <= o_alu_b;
    alu_out <= alu_f(alu_ar, alu_br, o_alu_op);
  end
  assign i_alu_result = alu_out[7:0];
  assign i_alu_carry  = alu_out[8];

  // Reference model: mk counts cycles since accept (0 = idle).
  int         mk = 0;
  logic [7:0] mrf [4] = '{default: 8'h00};
  logic [7:0] ma = 8'h00, mb = 8'h00, mres = 8'h00, mwb = 8'h00;
  logic [2:0] mop = 3'd0;
  logic [1:0] mrd = 2'd0;
  logic       mc = 1'b0, mcarry = 1'b0;

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mk = 0;
      for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
      ma = 8'h00; mb = 8'h00; mop = 3'd0; mrd = 2'd0;
      mres = 8'h00; mc = 1'b0; mwb = 8'h00; mcarry = 1'b0;
    end else if (mk == LAT) begin
      if (mrd != 2'd0) mrf[mrd] = mres;
      mwb = mres;
      mcarry = mc;
      mk = 0;
    end else if (mk != 0) begin
      mk++;
    end else if (i_cmd_valid) begin
      ma  = mrf[i_cmd_rs1];
      mb  = i_cmd_imm_en ? i_cmd_imm : mrf[i_cmd_rs2];
      mop = i_cmd_op;
      mrd = i_cmd_rd;
      {mc, mres} = alu_f(ma, mb, mop);
      mk = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge i_clk) begin
    chk("ready",    32'(o_cmd_ready),  32'(mk == 0));
    chk("busy",     32'(o_busy),       32'(mk != 0));
    chk("done",     32'(o_done),       32'(mk == LAT));
    chk("alu_a",    32'(o_alu_a),      32'(ma));
    chk("alu_b",    32'(o_alu_b),      32'(mb));
    chk("alu_op",   32'(o_alu_op),     32'(mop));
    chk("wb_data",  32'(o_wb_data),    32'(mwb));
    chk("carry",    32'(o_carry_flag), 32'(mcarry));
    chk("dbg_data", 32'(o_dbg_data),   32'(mrf[i_dbg_addr]));
  end

  // Present a command and wait (bounded) for the accepting edge; returns the
  // cycle number of that edge. keep=1 leaves valid asserted afterwards.
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                      input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm,
                      input logic keep, output int acc);
    i_cmd_op = op; i_cmd_rd = rd; i_cmd_rs1 = rs1; i_cmd_rs2 = rs2;
    i_cmd_imm_en = imm_en; i_cmd_imm = imm; i_cmd_valid = 1'b1;
    acc = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge i_clk);
      if (o_cmd_ready) begin
        @(posedge i_clk);
        #1;
        acc = cyc;
        break;
      end
    end
    if (!keep) i_cmd_valid = 1'b0;
    if (acc < 0) chk("accept_timeout", 0, 1);
  endtask

  // Called just after an accept; returns the cycle (1 = ISSUE) in which o_done rose.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge i_clk);
      if (o_done) begin
        lat = t;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    @(posedge i_clk);
    #1;
  endtask

  task automatic peek(input string name, input logic [1:0] addr, input logic [7:0] exp);
    i_dbg_addr = addr;
    #1;
    chk(name, 32'(o_dbg_data), 32'(exp));
  endtask

  int acc;
  int lat;
  int accs [3];

  initial begin
    #1 i_rstn = 1'b0;

    // 1: reset state
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_ready", 32'(o_cmd_ready), 1);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_done",  32'(o_done), 0);
    chk("rst_alu",   32'({o_alu_a, o_alu_b, o_alu_op}), 0);
    chk("rst_wb",    32'({o_wb_data, o_carry_flag}), 0);
    for (int a = 0; a < 4; a++) peek("rst_dbg", 2'(a), 8'h00);
    @(posedge i_clk);
    #1 i_rstn = 1'b1;

    // 2: ADD r1 = r0 + 0x7F
    send(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 1'b0, acc);
    wait_done(lat);
    chk("add_latency", lat, 3);
    peek("r1_7f", 2'd1, 8'h7F);
    chk("add_carry0", 32'(o_carry_flag), 0);

    // 3: ADD r2 = r1 + 0x81 (wraps), then XOR r3 = r1 ^ r1
    send(3'd0, 2'd2, 2'd1, 2'd0, 1'b1, 8'h81, 1'b0, acc);
    wait_done(lat);
    peek("r2_wrap", 2'd2, 8'h00);
    chk("add_carry1", 32'(o_carry_flag), 1);
    send(3'd4, 2'd3, 2'd1, 2'd1, 1'b0, 8'hFF, 1'b0, acc);
    wait_done(lat);
    peek("r3_xor", 2'd3, 8'h00);
    chk("xor_carry0", 32'(o_carry_flag), 0);

    // 4: SUB r3 = r1 - 1, op select held through WB
    send(3'd1, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0, acc);
    for (int t = 1; t <= 3; t++) begin
      @(negedge i_clk);
      chk("sub_op_hold", 32'(o_alu_op), 1);
      if (t == 3) chk("sub_done_wb", 32'(o_done), 1);
    end
    @(posedge i_clk);
    #1;
    peek("r3_sub", 2'd3, 8'h7E);
    chk("sub_carry1", 32'(o_carry_flag), 1);

    // 5: back-to-back with valid held high; first one targets r0
    send(3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h05, 1'b1, accs[0]);
    send(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01, 1'b1, accs[1]);
    send(3'd3, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, 1'b0, accs[2]);
    chk("spacing_0_1", accs[1] - accs[0], 4);
    chk("spacing_1_2", accs[2] - accs[1], 4);
    wait_done(lat);
    chk("burst_latency", lat, 3);
    peek("r0_zero", 2'd0, 8'h00);
    peek("r1_80", 2'd1, 8'h80);
    peek("r2_or", 2'd2, 8'hFE);

    // 6: reset during EXEC aborts the command
    send(3'd0, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01, 1'b0, acc);
    @(negedge i_clk);
    @(negedge i_clk);
    chk("exec_busy", 32'(o_busy), 1);
    #2 i_rstn = 1'b0;
    #1;
    chk("abort_done", 32'(o_done), 0);
    chk("abort_ready", 32'(o_cmd_ready), 1);
    peek("abort_r1", 2'd1, 8'h00);
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    peek("abort_r1_after", 2'd1, 8'h00);
    send(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h33, 1'b0, acc);
    wait_done(lat);
    chk("post_rst_latency", lat, 3);
    peek("r1_33", 2'd1, 8'h33);

    repeat (2) @(posedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
